mult_seq_ctrl: RTL

MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

---
 rtl/mult_pkg.sv | 16 +
 rtl/rca_Nbit_co.sv | 30 +++
 rtl/mult_seq_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared FSM state type and encodings for the sequential shift-add multiplier.
package mult_pkg;

   localparam logic [1:0] ST_IDLE_ENC = 2'b00;
   localparam logic [1:0] ST_CALC_ENC = 2'b01;
   localparam logic [1:0] ST_NEG_ENC  = 2'b10;
   localparam logic [1:0] ST_DONE_ENC = 2'b11;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE_ENC,
      CALC = ST_CALC_ENC,
      NEG  = ST_NEG_ENC,
      DONE = ST_DONE_ENC
   } mult_state_t;

endpackage

// File: rtl/rca_Nbit_co.sv
// N-bit ripple-carry adder with carry-in and carry-out.
module rca_Nbit_co #(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] s,
   output logic         cout
);

   logic [N-1:0] sum_s;
   logic         carry_s;

   // Bitwise full-adder chain; the carry lives in a block-local variable.
   always_comb begin
      logic c_v;
      sum_s = '0;
      c_v   = cin;
      for (int i = 0; i < N; i++) begin
         sum_s[i] = a[i] ^ b[i] ^ c_v;
         c_v      = (a[i] & b[i]) | (c_v & (a[i] ^ b[i]));
      end
      carry_s = c_v;
   end

   assign s    = sum_s;
   assign cout = carry_s;

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential shift-add multiplier controller; MULT_SEQ_SIGNED_EN selects the
// two's-complement build with magnitude conversion and a final NEG state.
module mult_seq_ctrl #(
   parameter int N = 4,
   parameter int M = 5
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [N-1:0]   A,
   input  logic [M-1:0]   B,
   output logic           busy,
   output logic           done,
   output logic [N+M-1:0] Prod
);
   import mult_pkg::*;

   localparam int W  = N + M;
   localparam int CW = (M > 1) ? $clog2(M) : 1;

   mult_state_t   state_q, state_d;
   logic [N-1:0]  a_mag_q, a_mag_d;
   logic [M-1:0]  b_q, b_d;
   logic [W-1:0]  acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [W-1:0]  prod_q, prod_d;
   logic [N-1:0]  a_load_s;
   logic [M-1:0]  b_load_s;
   logic [N-1:0]  addend_s;
   logic [N-1:0]  sum_s;
   logic          cout_s;
`ifdef MULT_SEQ_SIGNED_EN
   logic          sign_q, sign_d;
   logic          sign_load_s;
`endif

   assign addend_s = a_mag_q & {N{b_q[0]}};

   rca_Nbit_co #(.N(N)) u_rca (
      .a    (acc_q[W-1:M]),
      .b    (addend_s),
      .cin  (1'b0),
      .s    (sum_s),
      .cout (cout_s)
   );

   // Operand conditioning at accept time; zero operands force a positive sign.
   always_comb begin
`ifdef MULT_SEQ_SIGNED_EN
      if (A[N-1]) begin
         a_load_s = ~A + N'(1);
      end else begin
         a_load_s = A;
      end
      if (B[M-1]) begin
         b_load_s = ~B + M'(1);
      end else begin
         b_load_s = B;
      end
      sign_load_s = (A[N-1] ^ B[M-1]) & (A != '0) & (B != '0);
`else
      a_load_s = A;
      b_load_s = B;
`endif
   end

   // Next-state and datapath control.
   always_comb begin
      state_d = state_q;
      a_mag_d = a_mag_q;
      b_d     = b_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      done_d  = 1'b0;
`ifdef MULT_SEQ_SIGNED_EN
      sign_d  = sign_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               a_mag_d = a_load_s;
               b_d     = b_load_s;
               acc_d   = '0;
               cnt_d   = '0;
`ifdef MULT_SEQ_SIGNED_EN
               sign_d  = sign_load_s;
`endif
               state_d = CALC;
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            // Partial product goes into the upper N bits, then the whole word shifts right.
            acc_d = {cout_s, sum_s, acc_q[M-1:1]};
            b_d   = b_q >> 1;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(M - 1)) begin
`ifdef MULT_SEQ_SIGNED_EN
               state_d = NEG;
`else
               state_d = DONE;
`endif
            end else begin
               state_d = CALC;
            end
         end
`ifdef MULT_SEQ_SIGNED_EN
         NEG: begin
            if (sign_q) begin
               acc_d = ~acc_q + W'(1);
            end else begin
               acc_d = acc_q;
            end
            state_d = DONE;
         end
`endif
         DONE: begin
            prod_d  = acc_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_mag_q <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         prod_q  <= '0;
`ifdef MULT_SEQ_SIGNED_EN
         sign_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_mag_q <= a_mag_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         prod_q  <= prod_d;
`ifdef MULT_SEQ_SIGNED_EN
         sign_q  <= sign_d;
`endif
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign Prod = prod_q;

endmodule
